// File: rtl/hs_npu_pkg.sv
// Shared types and constants for the hs_npu memory-side blocks.
package hs_npu_pkg;

    localparam int unsigned UWORD_W         = 32;
    localparam int unsigned MEM_BURST_WORDS = 2;
    localparam int unsigned MEM_ARB_TIMEOUT = 1024;

    typedef logic [UWORD_W-1:0] uword_t;
    typedef uword_t [MEM_BURST_WORDS-1:0] burst_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd,
        StWaitWr
    } arb_state_t;

endpackage

// File: rtl/hs_npu_rr_picker.sv
// Combinational round-robin picker: first set request scanning from last+1.
module hs_npu_rr_picker #(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   sel,
    output logic               found
);

    int unsigned        cand;
    logic [IDX_W-1:0]   cand_idx;

    // Walk the ring once starting just after the previous winner.
    always_comb begin
        gnt      = '0;
        sel      = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand     = (32'(last) + i) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found         = 1'b1;
                gnt[cand_idx] = 1'b1;
                sel           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/hs_npu_mem_arbiter.sv
// Round-robin arbiter sharing the hs_npu memory port between NPU clients.
// The grant is held for a whole burst; a watchdog aborts hung transactions.
module hs_npu_mem_arbiter
    import hs_npu_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 3,
    parameter int unsigned BURST_WORDS = MEM_BURST_WORDS,
    parameter int unsigned TIMEOUT     = MEM_ARB_TIMEOUT
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic [NUM_REQ-1:0]                            req_valid_i,
    input  logic [NUM_REQ-1:0]                            req_write_i,
    input  logic [NUM_REQ-1:0][UWORD_W-1:0]               req_addr_i,
    input  logic [NUM_REQ-1:0][BURST_WORDS-1:0][UWORD_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]                            req_gnt_o,
    output logic [NUM_REQ-1:0]                            rsp_valid_o,
    output logic                                          rsp_err_o,
    output logic [BURST_WORDS-1:0][UWORD_W-1:0]           rsp_rdata_o,
    input  logic                                          mem_ready_i,
    input  logic                                          mem_valid_i,
    input  logic [BURST_WORDS-1:0][UWORD_W-1:0]           mem_rdata_i,
    input  logic                                          mem_wdone_i,
    output logic                                          mem_read_ready_o,
    output logic                                          mem_write_valid_o,
    output logic                                          mem_invalidate_o,
    output logic [UWORD_W-1:0]                            mem_addr_o,
    output logic [BURST_WORDS-1:0][UWORD_W-1:0]           mem_wdata_o,
    output logic [NUM_REQ-1:0]                            err_sticky_o,
    input  logic                                          err_clr_i
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    arb_state_t                          state_q, state_d;
    logic [IDX_W-1:0]                    last_q, owner_q;
    logic                                owner_write_q;
    logic [UWORD_W-1:0]                  addr_q;
    logic [BURST_WORDS-1:0][UWORD_W-1:0] wdata_q, rdata_q;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [NUM_REQ-1:0]                  rsp_valid_q, rsp_valid_d;
    logic                                rsp_err_q, rsp_err_d;
    logic [NUM_REQ-1:0]                  sticky_q, sticky_d;

    logic [NUM_REQ-1:0] pick_req, pick_gnt, owner_onehot;
    logic [IDX_W-1:0]   pick_sel;
    logic               pick_found, load_rdata, timeout_hit;

    // Only offer requests to the picker when a new burst may start.
    assign pick_req     = (state_q == StIdle && mem_ready_i) ? req_valid_i : '0;
    assign timeout_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign owner_onehot = NUM_REQ'(1) << owner_q;

    hs_npu_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req   (pick_req),
        .last  (last_q),
        .gnt   (pick_gnt),
        .sel   (pick_sel),
        .found (pick_found)
    );

    // Next-state, handshake outputs and watchdog decisions.
    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        rsp_valid_d       = '0;
        rsp_err_d         = 1'b0;
        sticky_d          = err_clr_i ? '0 : sticky_q;
        load_rdata        = 1'b0;
        mem_read_ready_o  = 1'b0;
        mem_write_valid_o = 1'b0;
        mem_invalidate_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    state_d = StIssue;
                    cnt_d   = '0;
                end
            end
            StIssue: begin
                if (owner_write_q) begin
                    mem_write_valid_o = 1'b1;
                    state_d           = StWaitWr;
                end else begin
                    mem_read_ready_o = 1'b1;
                    state_d          = StWaitRd;
                end
            end
            StWaitRd, StWaitWr: begin
                mem_read_ready_o = (state_q == StWaitRd);
                // Completion beats a watchdog expiry landing in the same cycle.
                if ((state_q == StWaitRd) ? mem_valid_i : mem_wdone_i) begin
                    load_rdata  = (state_q == StWaitRd);
                    rsp_valid_d = owner_onehot;
                    state_d     = StIdle;
                end else if (timeout_hit) begin
                    mem_invalidate_o  = 1'b1;
                    rsp_valid_d       = owner_onehot;
                    rsp_err_d         = 1'b1;
                    sticky_d[owner_q] = 1'b1;
                    state_d           = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Control state, watchdog and response pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            sticky_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            sticky_q    <= sticky_d;
        end
    end

    // Capture the winner's request fields; they drive the bus until IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q        <= IDX_W'(NUM_REQ - 1);
            owner_q       <= '0;
            owner_write_q <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
        end else if (pick_found) begin
            last_q        <= pick_sel;
            owner_q       <= pick_sel;
            owner_write_q <= req_write_i[pick_sel];
            addr_q        <= req_addr_i[pick_sel];
            wdata_q       <= req_wdata_i[pick_sel];
        end
    end

    // Read data register; holds until the next successful read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (load_rdata) begin
            rdata_q <= mem_rdata_i;
        end
    end

    assign req_gnt_o    = pick_gnt;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_err_o    = rsp_err_q;
    assign rsp_rdata_o  = rdata_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign err_sticky_o = sticky_q;

endmodule

// File: tb/tb_hs_npu_mem_arbiter.sv
// Self-checking bench for hs_npu_mem_arbiter: directed cases then random traffic.
module tb_hs_npu_mem_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned BW = 2;
    localparam int unsigned TO = 8;

    logic                         clk, rst_n;
    logic [NR-1:0]                req_valid_i, req_write_i;
    logic [NR-1:0][31:0]          req_addr_i;
    logic [NR-1:0][BW-1:0][31:0]  req_wdata_i;
    logic [NR-1:0]                req_gnt_o, rsp_valid_o;
    logic                         rsp_err_o;
    logic [BW-1:0][31:0]          rsp_rdata_o;
    logic                         mem_ready_i, mem_valid_i, mem_wdone_i;
    logic [BW-1:0][31:0]          mem_rdata_i;
    logic                         mem_read_ready_o, mem_write_valid_o, mem_invalidate_o;
    logic [31:0]                  mem_addr_o;
    logic [BW-1:0][31:0]          mem_wdata_o;
    logic [NR-1:0]                err_sticky_o;
    logic                         err_clr_i;

    hs_npu_mem_arbiter #(
        .NUM_REQ     (NR),
        .BURST_WORDS (BW),
        .TIMEOUT     (TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (req_valid_i),
        .req_write_i       (req_write_i),
        .req_addr_i        (req_addr_i),
        .req_wdata_i       (req_wdata_i),
        .req_gnt_o         (req_gnt_o),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_err_o         (rsp_err_o),
        .rsp_rdata_o       (rsp_rdata_o),
        .mem_ready_i       (mem_ready_i),
        .mem_valid_i       (mem_valid_i),
        .mem_rdata_i       (mem_rdata_i),
        .mem_wdone_i       (mem_wdone_i),
        .mem_read_ready_o  (mem_read_ready_o),
        .mem_write_valid_o (mem_write_valid_o),
        .mem_invalidate_o  (mem_invalidate_o),
        .mem_addr_o        (mem_addr_o),
        .mem_wdata_o       (mem_wdata_o),
        .err_sticky_o      (err_sticky_o),
        .err_clr_i         (err_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          model_last;
    logic [NR-1:0] exp_sticky;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference round-robin: first pending client after the last winner.
    function automatic int pick(input logic [NR-1:0] mask);
        for (int i = 1; i <= int'(NR); i++) begin
            int c;
            c = (model_last + i) % int'(NR);
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_req(input int c, input bit w, input logic [31:0] a,
                           input logic [63:0] d);
        req_write_i[c] = w;
        req_addr_i[c]  = a;
        req_wdata_i[c] = d;
        req_valid_i[c] = 1'b1;
    endtask

    // Grant + one whole burst. k = WAIT cycle that completes it (1..TO), 0 = never.
    task automatic run_txn(input int k, input logic [63:0] rd, input bit clr, output int w);
        bit          wr, tmo;
        logic [31:0] a;
        logic [63:0] wd;
        #1;
        w = pick(req_valid_i);
        if (w < 0) begin
            check("no_requester", 1, 0);
            return;
        end
        check("gnt", req_gnt_o, 128'(1) << w);
        model_last = w;
        wr = req_write_i[w];
        a  = req_addr_i[w];
        wd = req_wdata_i[w];
        @(posedge clk); #1;
        req_valid_i[w] = 1'b0;
        check("issue_rd", mem_read_ready_o, !wr);
        check("issue_wr", mem_write_valid_o, wr);
        check("issue_addr", mem_addr_o, a);
        check("issue_wdata", mem_wdata_o, wd);
        check("issue_nognt", req_gnt_o, 0);
        for (int c = 1; c <= int'(TO); c++) begin
            @(posedge clk); #1;
            check("wait_rd", mem_read_ready_o, !wr);
            check("wait_wr", mem_write_valid_o, 0);
            check("wait_addr", mem_addr_o, a);
            check("wait_wdata", mem_wdata_o, wd);
            check("wait_nognt", req_gnt_o, 0);
            if (k == c) begin
                if (wr) mem_wdone_i = 1'b1;
                else begin
                    mem_valid_i = 1'b1;
                    mem_rdata_i = rd;
                end
                #1 check("done_noinv", mem_invalidate_o, 0);
                break;
            end
            if (k == 0 && c == int'(TO)) begin
                err_clr_i = clr;
                #1 check("tmo_inv", mem_invalidate_o, 1);
                break;
            end
            check("wait_noinv", mem_invalidate_o, 0);
        end
        @(posedge clk); #1;
        mem_valid_i = 1'b0;
        mem_wdone_i = 1'b0;
        err_clr_i   = 1'b0;
        tmo = (k == 0);
        if (clr) exp_sticky = '0;
        if (tmo) exp_sticky[w] = 1'b1;
        check("rsp_valid", rsp_valid_o, 128'(1) << w);
        check("rsp_err", rsp_err_o, tmo);
        if (!wr && !tmo) check("rsp_rdata", rsp_rdata_o, rd);
        check("sticky", err_sticky_o, exp_sticky);
    endtask

    initial begin
        int          w;
        logic [63:0] held;
        rst_n       = 1'b0;
        req_valid_i = '0;
        req_write_i = '0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        mem_ready_i = 1'b0;
        mem_valid_i = 1'b0;
        mem_wdone_i = 1'b0;
        mem_rdata_i = '0;
        err_clr_i   = 1'b0;
        model_last  = int'(NR) - 1;
        exp_sticky  = '0;
        #12;
        check("rst_rsp_valid", rsp_valid_o, 0);
        check("rst_rdata", rsp_rdata_o, 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_sticky", err_sticky_o, 0);
        @(posedge clk); #1;
        rst_n       = 1'b1;
        mem_ready_i = 1'b1;

        // Single read from client 1, data arrives 4 cycles into WAIT_RD.
        set_req(1, 1'b0, 32'h100, 64'h0);
        run_txn(4, {32'hB, 32'hA}, 1'b0, w);
        // Single write from client 2.
        set_req(2, 1'b1, 32'h200, {32'h22, 32'h11});
        run_txn(3, 64'h0, 1'b0, w);
        @(posedge clk); #1;
        check("rsp_pulse", rsp_valid_o, 0);

        // Stray read data while idle must be ignored.
        held        = rsp_rdata_o;
        mem_valid_i = 1'b1;
        mem_rdata_i = 64'hDEAD_BEEF_0BAD_F00D;
        @(posedge clk); #1;
        mem_valid_i = 1'b0;
        @(posedge clk); #1;
        check("stray_valid", rsp_valid_o, 0);
        check("stray_rdata", rsp_rdata_o, held);

        // No grant while the interface is busy.
        mem_ready_i = 1'b0;
        for (int c = 0; c < int'(NR); c++) set_req(c, c[0], 32'h300 + 32'(c), 64'(c));
        #1 check("busy_nognt", req_gnt_o, 0);
        @(posedge clk); #1;
        check("busy_idle", mem_read_ready_o | mem_write_valid_o, 0);
        mem_ready_i = 1'b1;

        // Continuous requests rotate 0,1,2,0,1,2.
        for (int i = 0; i < 6; i++) begin
            run_txn(1 + i % 3, 64'(i) * 64'h1_0000_0001, 1'b0, w);
            set_req(w, w[0], 32'h300 + 32'(w), 64'(w));
        end
        req_valid_i = '0;

        // Watchdog on a read, then clear the sticky flag.
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h400, 64'h0);
        run_txn(0, 64'h0, 1'b0, w);
        err_clr_i = 1'b1;
        @(posedge clk); #1;
        err_clr_i  = 1'b0;
        exp_sticky = '0;
        check("sticky_clr", err_sticky_o, exp_sticky);
        // Completion in the same cycle the watchdog would fire.
        set_req(1, 1'b0, 32'h500, 64'h0);
        run_txn(int'(TO), 64'h1234_5678_9ABC_DEF0, 1'b0, w);
        // Write timeout together with err_clr: the new flag survives.
        set_req(1, 1'b0, 32'h600, 64'h0);
        run_txn(0, 64'h0, 1'b0, w);
        set_req(2, 1'b1, 32'h700, 64'h77);
        run_txn(0, 64'h0, 1'b1, w);

        // Random traffic against the model.
        for (int i = 0; i < 25; i++) begin
            int k;
            for (int c = 0; c < int'(NR); c++)
                if (!req_valid_i[c] && $urandom_range(0, 1) == 1)
                    set_req(c, 1'($urandom), $urandom, {$urandom, $urandom});
            if (req_valid_i == '0)
                set_req(int'($urandom_range(0, NR - 1)), 1'($urandom), $urandom,
                        {$urandom, $urandom});
            k = int'($urandom_range(0, TO));
            run_txn(k, {$urandom, $urandom}, (k == 0) && ($urandom_range(0, 1) == 1), w);
        end
        req_valid_i = '0;

        // Reset in the middle of a write drops everything.
        @(posedge clk); #1;
        set_req(2, 1'b1, 32'h800, 64'h88);
        #1 check("pre_rst_gnt", req_gnt_o, 3'b100);
        @(posedge clk); #1;
        req_valid_i = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_gnt", req_gnt_o, 0);
        check("rst_rsp", {rsp_valid_o, rsp_err_o}, 0);
        check("rst_rdata2", rsp_rdata_o, 0);
        check("rst_mem", {mem_read_ready_o, mem_write_valid_o, mem_invalidate_o}, 0);
        check("rst_addr2", mem_addr_o, 0);
        check("rst_wdata", mem_wdata_o, 0);
        check("rst_sticky2", err_sticky_o, 0);
        @(posedge clk); #1;
        rst_n      = 1'b1;
        model_last = int'(NR) - 1;
        exp_sticky = '0;
        for (int c = 0; c < int'(NR); c++) set_req(c, 1'b0, 32'h900 + 32'(c), 64'h0);
        run_txn(2, 64'h5555_AAAA_0000_FFFF, 1'b0, w);
        req_valid_i = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
